// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: streams inst_count words from the instruction memory's read port
// into a small response FIFO and hands them to the decoder over a valid/ready stream.
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   inst_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_last,
  input  logic                  inst_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        consumed;
  logic [CNT_W-1:0]        consumed_next;
  logic                    inflight;
  logic                    push;
  logic                    pop;
  logic [PTR_W:0]          occupancy;
  logic [PTR_W:0]          credit_used;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [DATA_WIDTH-1:0]   storage [FIFO_DEPTH];

  // A request is only issued when the FIFO has room for it and every earlier in-flight word.
  assign credit_used   = occupancy + {{PTR_W{1'b0}}, inflight};
  assign mem_read_req  = (state == FETCH) && (issued < count) && (credit_used < DEPTH);
  assign mem_read_addr = addr;

  assign push          = inflight;
  assign inst_valid    = (occupancy != '0);
  assign inst_data     = storage[rd_ptr];
  assign pop           = inst_valid & inst_ready;
  assign inst_last     = inst_valid && (consumed == count - 1'b1);
  assign consumed_next = consumed + {{ADDR_WIDTH{1'b0}}, pop};

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (inst_count != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (issued == count) begin
          next_state = DRAIN;
        end
      end
      // Looking at the post-pop count lets done follow the last handshake by one cycle.
      DRAIN: begin
        if (consumed_next == count) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      issued    <= '0;
      consumed  <= '0;
      inflight  <= 1'b0;
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state    <= next_state;
      inflight <= mem_read_req;
      if (state == IDLE && start) begin
        addr     <= start_addr;
        count    <= inst_count;
        issued   <= '0;
        consumed <= '0;
      end else begin
        if (mem_read_req) begin
          addr   <= addr + 1'b1;
          issued <= issued + 1'b1;
        end
        consumed <= consumed_next;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      storage[wr_ptr] <= mem_read_data;
    end
  end

endmodule
